player_move_scheduler: RTL



---
 rtl/pacman_pkg.sv | 65 ++++++
 rtl/key_press_tracker.sv | 95 +++++++++
 rtl/player_move_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pacman_pkg: shared types, keycodes and key classification helper    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    PACMAN = 1'b0,
    GHOST  = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_class_t;

  function automatic key_class_t classify_key(
    input logic [7:0] code,
    input logic [7:0] up_code,
    input logic [7:0] down_code,
    input logic [7:0] left_code,
    input logic [7:0] right_code
  );
    key_class_t r;
    r.valid = 1'b1;
    r.dir   = UP;
    if (code == up_code) begin
      r.dir = UP;
    end else if (code == down_code) begin
      r.dir = DOWN;
    end else if (code == left_code) begin
      r.dir = LEFT;
    end else if (code == right_code) begin
      r.dir = RIGHT;
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_press_tracker: per-player press detect, auto-repeat, pending    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module key_press_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter logic [7:0]  UP_CODE       = KEY_W,
  parameter logic [7:0]  DOWN_CODE     = KEY_S,
  parameter logic [7:0]  LEFT_CODE     = KEY_A,
  parameter logic [7:0]  RIGHT_CODE    = KEY_D
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [7:0] keycode_a_i,
  input  logic [7:0] keycode_b_i,
  input  logic       frame_tick_i,
  input  logic       grant_clr_i,
  output logic       held_o,
  output logic       pend_o,
  output logic [1:0] pend_dir_o
);

  localparam int unsigned    RCW      = (REPEAT_FRAMES == 0) ? 1 : $clog2(REPEAT_FRAMES + 1);
  localparam logic [RCW-1:0] REP_LAST = (REPEAT_FRAMES == 0) ? '0 : RCW'(REPEAT_FRAMES - 1);

  key_class_t     cls_a;
  key_class_t     cls_b;
  key_class_t     cur;
  logic           held_valid_q;
  dir_t           held_dir_q;
  logic [RCW-1:0] rep_cnt_q;
  logic [RCW-1:0] rep_cnt_d;
  logic           pend_q;
  logic           pend_d;
  dir_t           pend_dir_q;
  dir_t           pend_dir_d;
  logic           new_key;
  logic           rep_expire;
  logic           press;

  // Slot A has priority when both slots carry a key for this player.
  always_comb begin
    cls_a = classify_key(keycode_a_i, UP_CODE, DOWN_CODE, LEFT_CODE, RIGHT_CODE);
    cls_b = classify_key(keycode_b_i, UP_CODE, DOWN_CODE, LEFT_CODE, RIGHT_CODE);
    cur   = cls_a.valid ? cls_a : cls_b;
  end

  assign new_key    = cur.valid && (!held_valid_q || (cur.dir != held_dir_q));
  assign rep_expire = (REPEAT_FRAMES != 0) && cur.valid && !new_key &&
                      frame_tick_i && (rep_cnt_q == REP_LAST);
  assign press      = new_key || rep_expire;

  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    if (!cur.valid || press) begin
      rep_cnt_d = '0;
    end else if (frame_tick_i) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
    // A fresh press outranks a same-cycle grant so the new request survives.
    if (press) begin
      pend_d     = 1'b1;
      pend_dir_d = cur.dir;
    end else if (grant_clr_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid_q <= 1'b0;
      held_dir_q   <= UP;
      rep_cnt_q    <= '0;
      pend_q       <= 1'b0;
      pend_dir_q   <= UP;
    end else begin
      held_valid_q <= cur.valid;
      held_dir_q   <= cur.dir;
      rep_cnt_q    <= rep_cnt_d;
      pend_q       <= pend_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  assign held_o     = held_valid_q;
  assign pend_o     = pend_q;
  assign pend_dir_o = pend_dir_q;

endmodule
`default_nettype wire

// File: rtl/player_move_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | player_move_scheduler: round-robin keyboard-to-movement arbiter     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module player_move_scheduler
  import pacman_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [7:0] keycode_a,
  input  logic [7:0] keycode_b,
  input  logic       frame_tick,
  input  logic       mv_ack,
  output logic       mv_req,
  output logic       mv_player,
  output logic [1:0] mv_dir,
  output logic       pacman_held,
  output logic       ghost_held,
  output logic       timeout_pulse
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  logic [1:0]   pend;
  logic [1:0]   grant_clr;
  logic [1:0]   pac_pend_dir;
  logic [1:0]   ghost_pend_dir;

  sched_state_t state_q;
  sched_state_t state_d;
  player_t      rr_ptr_q;
  player_t      rr_ptr_d;
  player_t      mv_player_q;
  player_t      mv_player_d;
  logic [1:0]   mv_dir_q;
  logic [1:0]   mv_dir_d;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic         timeout_q;
  logic         timeout_d;
  player_t      grant_player;

  key_press_tracker #(
    .REPEAT_FRAMES (REPEAT_FRAMES),
    .UP_CODE       (KEY_W),
    .DOWN_CODE     (KEY_S),
    .LEFT_CODE     (KEY_A),
    .RIGHT_CODE    (KEY_D)
  ) u_pac_tracker (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .keycode_a_i  (keycode_a),
    .keycode_b_i  (keycode_b),
    .frame_tick_i (frame_tick),
    .grant_clr_i  (grant_clr[0]),
    .held_o       (pacman_held),
    .pend_o       (pend[0]),
    .pend_dir_o   (pac_pend_dir)
  );

  key_press_tracker #(
    .REPEAT_FRAMES (REPEAT_FRAMES),
    .UP_CODE       (KEY_UP),
    .DOWN_CODE     (KEY_DOWN),
    .LEFT_CODE     (KEY_LEFT),
    .RIGHT_CODE    (KEY_RIGHT)
  ) u_ghost_tracker (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .keycode_a_i  (keycode_a),
    .keycode_b_i  (keycode_b),
    .frame_tick_i (frame_tick),
    .grant_clr_i  (grant_clr[1]),
    .held_o       (ghost_held),
    .pend_o       (pend[1]),
    .pend_dir_o   (ghost_pend_dir)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    mv_player_d  = mv_player_q;
    mv_dir_d     = mv_dir_q;
    tmr_d        = tmr_q;
    timeout_d    = 1'b0;
    grant_player = rr_ptr_q;
    grant_clr    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pend != 2'b00) begin
          if (pend != 2'b11) begin
            grant_player = pend[1] ? GHOST : PACMAN;
          end
          mv_player_d = grant_player;
          mv_dir_d    = (grant_player == GHOST) ? ghost_pend_dir : pac_pend_dir;
          grant_clr   = (grant_player == GHOST) ? 2'b10 : 2'b01;
          tmr_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mv_ack) begin
          state_d  = GAP;
          rr_ptr_d = (mv_player_q == PACMAN) ? GHOST : PACMAN;
        end else if (tmr_q == TMO_LAST) begin
          state_d   = GAP;
          rr_ptr_d  = (mv_player_q == PACMAN) ? GHOST : PACMAN;
          timeout_d = 1'b1;
        end else if (tmr_q != TMO_MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PACMAN;
      mv_player_q <= PACMAN;
      mv_dir_q    <= 2'd0;
      tmr_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mv_player_q <= mv_player_d;
      mv_dir_q    <= mv_dir_d;
      tmr_q       <= tmr_d;
      timeout_q   <= timeout_d;
    end
  end

  // Decoded from the state register so reset removes the request immediately.
  assign mv_req        = (state_q == REQ);
  assign mv_player     = mv_player_q;
  assign mv_dir        = mv_dir_q;
  assign timeout_pulse = timeout_q;

endmodule
`default_nettype wire
